periph_bus_master: RTL and testbench
====================================

# periph_bus_master

Initiator side of the peripheral register bus: accepts single load/store requests from the core over a valid/ready handshake and drives the peripheral port (`write`, `data_be`, `addr`, `wdata`, `rdata`) used by the timer and the other memory-mapped peripherals. It steers the byte enables, checks alignment, samples read data and returns a sized, sign- or zero-extended response. One transaction is in flight at a time. Peripherals answer combinationally with zero wait states.

## Interface
- `ADDR_W`, default 5: peripheral address width, byte addressed.
- `clk_i` input 1: clock.
- `rst_i` input 1: reset. Asynchronous and active-low.
- `req_valid_i` input 1: core request valid.
- `req_ready_o` output 1: request accepted when high together with `req_valid_i`.
- `req_write_i` input 1: 1 = store, 0 = load.
- `req_size_i` input 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_signed_i` input 1: sign-extend load data.
- `req_addr_i` input ADDR_W: byte address.
- `req_wdata_i` input 32: store data, right-aligned.
- `rsp_valid_o` output 1: response valid.
- `rsp_ready_i` input 1: core accepts the response.
- `rsp_rdata_o` output 32: extended load data. Always 0 for stores.
- `rsp_err_o` output 1: request rejected, no bus access performed.
- `write_o` output 1: peripheral write strobe.
- `data_be_o` output 4: byte enables.
- `addr_o` output ADDR_W: peripheral address.
- `wdata_o` output 32: peripheral write data.
- `rdata_i` input 32: peripheral read data. Combinational from `addr_o`, right-aligned.

## Operation
- FSM states: IDLE, ACCESS, RESP. `req_ready_o` = (state == IDLE).
- **IDLE, on handshake:**
  - Illegal request → RESP directly, with `rsp_err_o` = 1 and `rsp_rdata_o` = 0. A request is illegal when any of these holds:
    - `req_size_i` = 11
    - half at an odd address
    - word with `addr[1:0]` ≠ 0
  - Legal request → register `addr_o`, `wdata_o` (store data passed through unmasked), `data_be_o` (byte 0001, half 0011, word 1111), size and signed; go to ACCESS.
- **ACCESS (exactly one cycle):**
  - Store: `write_o` = 1.
  - Load: `write_o` = 0; `rdata_i` is captured at the end of the cycle.
  - Go to RESP.
- **Load data processing:** mask the captured data to the size (byte [7:0], half [15:0], word [31:0]). Extend from bit 7 or bit 15 when `req_signed` is set, otherwise zero-extend. Word loads are never extended.
- **RESP:** `rsp_valid_o` = 1 and the response payload is held stable until `rsp_ready_i` is high. Then go to IDLE.
- **Outside ACCESS:**
  - `write_o` = 0.
  - `data_be_o` = 0.
  - `addr_o` and `wdata_o` keep their last values. Reads of the last address are harmless because peripheral reads have no side effects.
- **Reset (asynchronous, any state):**
  - State → IDLE. A transaction in flight is abandoned with no response.
  - `write_o` 0, `data_be_o` 0, `addr_o` 0, `wdata_o` 0.
  - `rsp_valid_o` 0, `rsp_rdata_o` 0, `rsp_err_o` 0.
  - `req_ready_o` 1.
- **Reset during ACCESS of a store:** `write_o` drops immediately (asynchronous). The peripheral register update is not guaranteed.

## Timing
- Handshake at edge T:
  - ACCESS is during cycle T+1.
  - `write_o` is high for exactly the cycle T+1.
  - `rsp_valid_o` is high from T+2.
- Error path: `rsp_valid_o` is high from T+1. `write_o` and `data_be_o` stay 0 throughout.
- Response handshake at edge R: `req_ready_o` is high at R+1. The next request can be accepted at R+1, giving at best 3 cycles per legal access.
- `rsp_ready_i` may be held high before `rsp_valid_o`. The response still lasts at least one cycle.
- `req_*` inputs are sampled only at the handshake edge. Changes at any other time are ignored.
- `rdata_i` is sampled only at the end of a load ACCESS cycle.

## Structure
- Package `periph_bus_pkg` holds:
  - size codes `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`
  - FSM state encoding
  - a function mapping size to `data_be`
- Sub-module `load_ext`: combinational mask and sign/zero extension (inputs data, size, signed). It is reused by the core's data-memory path.
- Everything else lives in `periph_bus_master`.

## Test plan
- **Word store:** store word 0x0000_0010 to 0x00.
  - T+1: `write_o` = 1, `data_be_o` = 1111, `addr_o` = 0x00, `wdata_o` = 0x10.
  - T+2: `rsp_valid_o` = 1, `rsp_err_o` = 0.
- **Signed half load:** `rdata_i` = 0x1234_8001, address 0x02.
  - T+1: `data_be_o` = 0011.
  - Response: `rsp_rdata_o` = 0xFFFF_8001.
  - Same access unsigned: 0x0000_8001.
- **Byte loads:** `rdata_i` = 0x0000_00F0, address 0x1C.
  - Signed byte load → 0xFFFF_FFF0.
  - Unsigned byte load → 0x0000_00F0.
- **Illegal requests:** word at 0x06, half at 0x03, size 11.
  - Each gives `rsp_err_o` = 1 at T+1, with `write_o` and `data_be_o` 0 throughout.
- **Back-pressure:** `rsp_ready_i` low for 3 cycles in RESP.
  - `rsp_valid_o` and the payload are held stable.
  - `req_ready_o` = 0, and a new `req_valid_i` is not accepted.
  - Accepted one cycle after `rsp_ready_i` rises.
- **Reset during a store:** assert `rst_i` low during ACCESS of a store.
  - `write_o` and `data_be_o` go to 0 immediately; `rsp_valid_o` 0, `req_ready_o` 1.
  - After release, a new load completes normally.

Source files
------------

// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral register bus: size codes, master
// FSM encoding and the size-to-byte-enable mapping.
package periph_bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    // Byte enables for a right-aligned access of the given size.
    function automatic logic [3:0] size_to_be(input logic [1:0] size);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001;
            SZ_HALF: be = 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/periph_bus_master_if.sv
// Peripheral port of the register bus. The master drives the strobe,
// byte enables, address and write data; the peripheral returns read data
// combinationally from the address.
interface periph_bus_master_if #(
    parameter int ADDR_W = 5
);
    logic              write;
    logic [3:0]        data_be;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;

    modport master (
        output write,
        output data_be,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  write,
        input  data_be,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/periph_bus_master_load_ext.sv
// Combinational load-data sizing: keeps the low bytes that belong to the
// access and fills the rest with zero or with the sign bit of the access.
module load_ext
    import periph_bus_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] result
);
    logic fill;

    // Fill bit: sign of the byte or half when signed, otherwise zero.
    always_comb begin
        fill = sign_ext & ((size == SZ_BYTE) ? data[7] : data[15]);
    end

    assign result[7:0] = data[7:0];

    // Each upper lane is kept once the access is wide enough to cover it;
    // word (and the unused code 11) passes all lanes, so never extends.
    genvar gi;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] KEEP_FROM = (gi == 1) ? SZ_HALF : SZ_WORD;
            assign result[gi*8 +: 8] = (size >= KEEP_FROM) ? data[gi*8 +: 8] : {8{fill}};
        end
    endgenerate
endmodule

// File: rtl/periph_bus_master.sv
// Initiator of the peripheral register bus: one load/store at a time,
// alignment check, single-cycle peripheral access and sized response.
module periph_bus_master
    import periph_bus_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_signed_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    periph_bus_master_if.master bus
);
    state_e            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [3:0]        be_reg;
    logic [1:0]        size_reg;
    logic              signed_reg;
    logic              write_reg;
    logic              err_reg;
    logic [31:0]       rdata_reg;
    logic              req_illegal;
    logic              req_fire;
    logic [31:0]       load_data;

    assign req_fire = (state_reg == ST_IDLE) && req_valid_i;

    // Reject illegal sizes and misaligned half/word accesses.
    always_comb begin
        req_illegal = 1'b0;
        case (req_size_i)
            SZ_HALF: req_illegal = req_addr_i[0];
            SZ_WORD: req_illegal = (req_addr_i[1:0] != 2'b00);
            SZ_ILL:  req_illegal = 1'b1;
            default: req_illegal = 1'b0;
        endcase
    end

    load_ext u_load_ext (
        .data     (bus.rdata),
        .size     (size_reg),
        .sign_ext (signed_reg),
        .result   (load_data)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: errors skip the bus access, legal requests spend one cycle in ACCESS.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (req_valid_i) state_next = req_illegal ? ST_RESP : ST_ACCESS;
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   if (rsp_ready_i) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Request capture at the handshake and load-data capture at the end of ACCESS.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_reg   <= '0;
            wdata_reg  <= '0;
            be_reg     <= '0;
            size_reg   <= SZ_BYTE;
            signed_reg <= 1'b0;
            write_reg  <= 1'b0;
            err_reg    <= 1'b0;
            rdata_reg  <= '0;
        end else if (req_fire) begin
            err_reg   <= req_illegal;
            rdata_reg <= '0;
            // An illegal request leaves the bus registers untouched.
            if (!req_illegal) begin
                addr_reg   <= req_addr_i;
                wdata_reg  <= req_wdata_i;
                be_reg     <= size_to_be(req_size_i);
                size_reg   <= req_size_i;
                signed_reg <= req_signed_i;
                write_reg  <= req_write_i;
            end
        end else if ((state_reg == ST_ACCESS) && !write_reg) begin
            rdata_reg <= load_data;
        end
    end

    // Strobe and enables decode from the state so reset drops them at once.
    assign bus.write    = (state_reg == ST_ACCESS) && write_reg;
    assign bus.data_be  = (state_reg == ST_ACCESS) ? be_reg : 4'b0000;
    assign bus.addr     = addr_reg;
    assign bus.wdata    = wdata_reg;

    assign req_ready_o  = (state_reg == ST_IDLE);
    assign rsp_valid_o  = (state_reg == ST_RESP);
    assign rsp_rdata_o  = rdata_reg;
    assign rsp_err_o    = err_reg;
endmodule

// File: tb/tb_periph_bus_master.sv
// Directed bench for periph_bus_master: stores, sized loads, illegal
// requests, response back-pressure and reset in the middle of a store.
module tb_periph_bus_master;
    import periph_bus_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] periph_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    periph_bus_master_if #(.ADDR_W(5)) bus ();
    assign bus.rdata = periph_rdata;

    periph_bus_master #(.ADDR_W(5)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_size_i   (req_size),
        .req_signed_i (req_signed),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, let the handshake edge pass, then withdraw it.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [4:0] a, input logic [31:0] d);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = d;
        tick();
        req_valid  = 1'b0;
        req_wdata  = 32'h0BAD_0BAD;
        req_addr   = 5'h1F;
    endtask

    // Accept the response and confirm the master is back in IDLE.
    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        tick();
        chk({tag, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
        rsp_ready = 1'b0;
    endtask

    // Load that completes in RESP one cycle after the ACCESS cycle.
    task automatic load_check(input string tag, input logic [1:0] sz, input logic sg,
                              input logic [4:0] a, input logic [31:0] rd,
                              input logic [31:0] exp);
        periph_rdata = rd;
        issue(1'b0, sz, sg, a, 32'h0);
        chk({tag, "_write"}, {31'd0, bus.write}, 32'd0);
        chk({tag, "_be"}, {28'd0, bus.data_be}, {28'd0, size_to_be(sz)});
        tick();
        periph_rdata = 32'h5A5A_5A5A;
        chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_err"}, {31'd0, rsp_err}, 32'd0);
        chk({tag, "_rdata"}, rsp_rdata, exp);
        finish_rsp(tag);
    endtask

    // Illegal request: response the cycle after the handshake, bus idle.
    task automatic illegal_check(input string tag, input logic [1:0] sz, input logic [4:0] a,
                                 input logic [4:0] last_addr);
        issue(1'b1, sz, 1'b0, a, 32'hFFFF_FFFF);
        chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_err"}, {31'd0, rsp_err}, 32'd1);
        chk({tag, "_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_write"}, {31'd0, bus.write}, 32'd0);
        chk({tag, "_be"}, {28'd0, bus.data_be}, 32'd0);
        chk({tag, "_addr"}, {27'd0, bus.addr}, {27'd0, last_addr});
        finish_rsp(tag);
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = SZ_BYTE;
        req_signed   = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b0;
        periph_rdata = '0;

        // Reset state
        tick();
        tick();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_write", {31'd0, bus.write}, 32'd0);
        chk("rst_be", {28'd0, bus.data_be}, 32'd0);
        chk("rst_addr", {27'd0, bus.addr}, 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Word store of 0x10 to 0x00
        issue(1'b1, SZ_WORD, 1'b0, 5'h00, 32'h0000_0010);
        chk("wst_write", {31'd0, bus.write}, 32'd1);
        chk("wst_be", {28'd0, bus.data_be}, 32'hF);
        chk("wst_addr", {27'd0, bus.addr}, 32'h00);
        chk("wst_wdata", bus.wdata, 32'h0000_0010);
        chk("wst_ready_busy", {31'd0, req_ready}, 32'd0);
        chk("wst_valid_t1", {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("wst_valid", {31'd0, rsp_valid}, 32'd1);
        chk("wst_err", {31'd0, rsp_err}, 32'd0);
        chk("wst_rdata", rsp_rdata, 32'd0);
        chk("wst_write_t2", {31'd0, bus.write}, 32'd0);
        chk("wst_be_t2", {28'd0, bus.data_be}, 32'd0);
        chk("wst_addr_hold", {27'd0, bus.addr}, 32'h00);
        finish_rsp("wst");

        // Sized loads
        load_check("lh_s", SZ_HALF, 1'b1, 5'h02, 32'h1234_8001, 32'hFFFF_8001);
        load_check("lh_u", SZ_HALF, 1'b0, 5'h02, 32'h1234_8001, 32'h0000_8001);
        load_check("lb_s", SZ_BYTE, 1'b1, 5'h1C, 32'h0000_00F0, 32'hFFFF_FFF0);
        load_check("lb_u", SZ_BYTE, 1'b0, 5'h1C, 32'h0000_00F0, 32'h0000_00F0);
        load_check("lb_s_pos", SZ_BYTE, 1'b1, 5'h1D, 32'hFFFF_FF70, 32'h0000_0070);
        load_check("lw_s", SZ_WORD, 1'b1, 5'h04, 32'h8000_0001, 32'h8000_0001);
        chk("lw_addr", {27'd0, bus.addr}, 32'h04);

        // Illegal requests; the bus address keeps the last legal access
        illegal_check("ill_word", SZ_WORD, 5'h06, 5'h04);
        illegal_check("ill_half", SZ_HALF, 5'h03, 5'h04);
        illegal_check("ill_size", SZ_ILL, 5'h00, 5'h04);

        // Back-pressure on a word load; a competing request must wait
        periph_rdata = 32'hCAFE_F00D;
        issue(1'b0, SZ_WORD, 1'b0, 5'h08, 32'h0);
        tick();
        periph_rdata = 32'h1111_1111;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = SZ_BYTE;
        req_signed = 1'b0;
        req_addr   = 5'h10;
        req_wdata  = 32'h0000_00AB;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rdata", rsp_rdata, 32'hCAFE_F00D);
            chk("bp_err", {31'd0, rsp_err}, 32'd0);
            chk("bp_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_write", {31'd0, bus.write}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_rel_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_rel_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_rel_write", {31'd0, bus.write}, 32'd0);
        tick();
        req_valid = 1'b0;
        chk("bp_next_write", {31'd0, bus.write}, 32'd1);
        chk("bp_next_be", {28'd0, bus.data_be}, 32'h1);
        chk("bp_next_addr", {27'd0, bus.addr}, 32'h10);
        chk("bp_next_wdata", bus.wdata, 32'h0000_00AB);
        // rsp_ready held high in advance: response still lasts one cycle
        tick();
        chk("early_ready_valid", {31'd0, rsp_valid}, 32'd1);
        tick();
        chk("early_ready_done", {31'd0, rsp_valid}, 32'd0);
        chk("early_ready_idle", {31'd0, req_ready}, 32'd1);
        rsp_ready = 1'b0;

        // Reset in the middle of a store's ACCESS cycle
        issue(1'b1, SZ_WORD, 1'b0, 5'h0C, 32'h0000_0055);
        chk("rs_write_pre", {31'd0, bus.write}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_write", {31'd0, bus.write}, 32'd0);
        chk("rs_be", {28'd0, bus.data_be}, 32'd0);
        chk("rs_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rs_ready", {31'd0, req_ready}, 32'd1);
        chk("rs_addr", {27'd0, bus.addr}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rs_no_rsp", {31'd0, rsp_valid}, 32'd0);
        load_check("rs_load", SZ_HALF, 1'b0, 5'h0E, 32'h0000_BEEF, 32'h0000_BEEF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
